ep6_frame_packer: RTL and testbench

- Sits on the IFCLK side between the ADC sample FIFO read port and the FX2 slave-FIFO EP6 interface. It replaces the free-running word pump.
- Packs ADC words into fixed 512-byte frames: two sync words, a 16-bit frame counter, then PAYLOAD_WORDS samples. Host software can therefore re-align the stream and detect dropped packets.
- Starts a frame only when a full payload is already buffered, so the source never underruns mid-frame. Stalls cleanly on FX2 back-pressure.

---
 rtl/ep6_frame_packer.sv | 117 +++++++++++
 tb/tb_ep6_frame_packer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ep6_frame_packer.sv
// ep6_frame_packer: packs ADC FIFO words into 256-word sync/counter-headed EP6 frames
module ep6_frame_packer #(
    parameter int          PAYLOAD_WORDS = 253,
    parameter logic [15:0] SYNC_WORD     = 16'h7F7F,
    parameter int          USEDW_W       = 10
) (
    input  logic               IFCLK,
    input  logic               RST_N,
    input  logic               RUN,
    input  logic [15:0]        FIFO_Q,
    input  logic [USEDW_W-1:0] FIFO_RDUSEDW,
    output logic               FIFO_RDREQ,
    input  logic               FULL_N,
    output logic [15:0]        FD,
    output logic               SLWR_N,
    output logic [1:0]         FIFO_ADR,
    output logic [15:0]        FRAME_CNT,
    output logic               BUSY
);
    localparam int CNT_W = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [CNT_W-1:0] REQ_MAX = CNT_W'(PAYLOAD_WORDS);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PAYLOAD_WORDS - 1);
    localparam logic [2:0] IDLE = 3'd0, HDR0 = 3'd1, HDR1 = 3'd2, HDR2 = 3'd3, DATA = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [15:0]      seq_q, seq_d, fd_q, fd_d, frame_cnt_q, frame_cnt_d;
    logic [15:0]      buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]       occ_q, occ_d, occ_n;
    logic             slwr_n_q, slwr_n_d, inflight_q, inflight_d;
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d, wr_cnt_q, wr_cnt_d;
    logic             rdreq, wr_data, pop, push;
    logic [15:0]      data_word;

    // Next-state: prefetch into a 2-deep buffer (with bypass of the arriving word) and sequence the frame
    always_comb begin
        rdreq       = (state_q == HDR2 || state_q == DATA) && (occ_q + {1'b0, inflight_q} < 2'd2) && (req_cnt_q < REQ_MAX);
        wr_data     = state_q == DATA && FULL_N && (occ_q != 2'd0 || inflight_q);
        pop         = wr_data && occ_q != 2'd0;
        push        = inflight_q && !(wr_data && occ_q == 2'd0);
        data_word   = occ_q != 2'd0 ? buf0_q : FIFO_Q;
        occ_n       = occ_q - {1'b0, pop};
        buf0_d      = pop ? buf1_q : buf0_q;
        buf1_d      = buf1_q;
        if (push && occ_n == 2'd0) buf0_d = FIFO_Q;
        if (push && occ_n != 2'd0) buf1_d = FIFO_Q;
        occ_d       = occ_n + {1'b0, push};
        inflight_d  = rdreq;
        req_cnt_d   = state_q == IDLE ? '0 : req_cnt_q + CNT_W'(rdreq);
        state_d     = state_q;
        seq_d       = seq_q;
        fd_d        = fd_q;
        slwr_n_d    = 1'b1;
        frame_cnt_d = frame_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        case (state_q)
            IDLE: if (RUN && FIFO_RDUSEDW >= USEDW_W'(PAYLOAD_WORDS)) state_d = HDR0;
            HDR0, HDR1: if (FULL_N) begin
                fd_d     = SYNC_WORD;
                slwr_n_d = 1'b0;
                state_d  = state_q == HDR0 ? HDR1 : HDR2;
            end
            HDR2: if (FULL_N) begin
                fd_d     = seq_q;
                slwr_n_d = 1'b0;
                seq_d    = seq_q + 16'd1;
                wr_cnt_d = '0;
                state_d  = DATA;
            end
            DATA: if (wr_data) begin
                fd_d     = data_word;
                slwr_n_d = 1'b0;
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
                if (wr_cnt_q == LAST) begin
                    state_d     = IDLE;
                    frame_cnt_d = seq_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any partial frame
    always_ff @(posedge IFCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            fd_q        <= '0;
            slwr_n_q    <= 1'b1;
            frame_cnt_q <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            occ_q       <= '0;
            inflight_q  <= 1'b0;
            req_cnt_q   <= '0;
            wr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            fd_q        <= fd_d;
            slwr_n_q    <= slwr_n_d;
            frame_cnt_q <= frame_cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            req_cnt_q   <= req_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign FIFO_RDREQ = rdreq;
    assign FD         = fd_q;
    assign SLWR_N     = slwr_n_q;
    assign FIFO_ADR   = 2'b10;
    assign FRAME_CNT  = frame_cnt_q;
    assign BUSY       = state_q != IDLE;
endmodule

// File: tb/tb_ep6_frame_packer.sv
// tb_ep6_frame_packer: scoreboard bench for the EP6 frame packer
module tb_ep6_frame_packer;
    logic        IFCLK = 1'b0, RST_N = 1'b0, RUN = 1'b0, FULL_N = 1'b1;
    logic [15:0] FIFO_Q = '0;
    logic [9:0]  FIFO_RDUSEDW = '0;
    logic        FIFO_RDREQ, SLWR_N, BUSY;
    logic [15:0] FD, FRAME_CNT;
    logic [1:0]  FIFO_ADR;

    int          checks = 0, errors = 0;
    int          wr_cnt = 0, rd_cnt = 0, run_len = 0, max_run = 0;
    logic [15:0] exp_q[$];
    logic [15:0] ramp = '0, exp_ramp = '0;
    logic        rdreq_s = 1'b0;

    ep6_frame_packer dut (
        .IFCLK(IFCLK), .RST_N(RST_N), .RUN(RUN), .FIFO_Q(FIFO_Q), .FIFO_RDUSEDW(FIFO_RDUSEDW),
        .FIFO_RDREQ(FIFO_RDREQ), .FULL_N(FULL_N), .FD(FD), .SLWR_N(SLWR_N),
        .FIFO_ADR(FIFO_ADR), .FRAME_CNT(FRAME_CNT), .BUSY(BUSY)
    );

    always #5 IFCLK = ~IFCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge IFCLK);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] hdr);
        exp_q.push_back(16'h7F7F);
        exp_q.push_back(16'h7F7F);
        exp_q.push_back(hdr);
        for (int i = 0; i < 253; i++) begin
            exp_q.push_back(exp_ramp);
            exp_ramp = exp_ramp + 16'd1;
        end
    endtask

    task automatic wait_busy;
        int n = 0;
        while (!BUSY && n < 50) begin cyc; n++; end
        chk("busy_timeout", 32'(BUSY), 32'd1);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < lim) begin cyc; n++; end
        chk("done_timeout", 32'(exp_q.size() == 0 && !BUSY), 32'd1);
    endtask

    task automatic one_frame(input logic [15:0] hdr);
        push_frame(hdr);
        RUN = 1'b1;
        wait_busy;
        RUN = 1'b0;
        wait_done(600);
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (wr_cnt < target && n < 600) begin cyc; n++; end
        chk("wr_wait_timeout", 32'(wr_cnt), 32'(target));
    endtask

    // Non-show-ahead FIFO model: data appears the cycle after the request
    always @(posedge IFCLK) if (RST_N && rdreq_s) begin
        FIFO_Q <= ramp;
        ramp   <= ramp + 16'd1;
    end

    // Write monitor: every low-SLWR_N cycle must deliver the next expected word
    always @(negedge IFCLK) begin
        rdreq_s <= FIFO_RDREQ;
        if (RST_N) begin
            if (FIFO_RDREQ) rd_cnt++;
            if (!SLWR_N) begin
                wr_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) chk("spurious_wr", 32'(SLWR_N), 32'd1);
                else chk("fd", 32'(FD), 32'(exp_q.pop_front()));
            end else run_len = 0;
        end
    end

    initial begin
        int base_wr, base_rd, n, starts;
        logic prev;
        FIFO_RDUSEDW = 10'd300;
        repeat (3) cyc;
        chk("rst_fd", 32'(FD), 32'd0);
        chk("rst_slwr_n", 32'(SLWR_N), 32'd1);
        chk("rst_rdreq", 32'(FIFO_RDREQ), 32'd0);
        chk("rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("fifo_adr", 32'(FIFO_ADR), 32'd2);
        RST_N = 1'b1;
        cyc;
        max_run = 0;
        base_rd = rd_cnt;
        one_frame(16'h0000);
        chk("t1_max_run", 32'(max_run), 32'd256);
        chk("t1_rdreq_pulses", 32'(rd_cnt - base_rd), 32'd253);
        chk("t1_frame_cnt", 32'(FRAME_CNT), 32'd0);
        FIFO_RDUSEDW = 10'd252;
        RUN = 1'b1;
        base_wr = wr_cnt;
        base_rd = rd_cnt;
        repeat (20) cyc;
        chk("t2_idle_wr", 32'(wr_cnt - base_wr), 32'd0);
        chk("t2_idle_rd", 32'(rd_cnt - base_rd), 32'd0);
        chk("t2_idle_busy", 32'(BUSY), 32'd0);
        push_frame(16'h0001);
        FIFO_RDUSEDW = 10'd253;
        n = 0;
        while (!BUSY && n < 10) begin cyc; n++; end
        chk("t2_start_within2", 32'(n >= 1 && n <= 2), 32'd1);
        RUN = 1'b0;
        wait_done(600);
        chk("t2_frame_cnt", 32'(FRAME_CNT), 32'd1);
        RST_N = 1'b0;
        cyc;
        cyc;
        RST_N = 1'b1;
        cyc;
        FIFO_RDUSEDW = 10'd300;
        for (int h = 0; h < 4; h++) push_frame(16'(h));
        base_rd = rd_cnt;
        RUN = 1'b1;
        starts = 0;
        prev = 1'b0;
        n = 0;
        while (n < 8000 && (starts < 4 || exp_q.size() != 0 || BUSY)) begin
            FULL_N = 1'($urandom_range(0, 1));
            cyc;
            if (BUSY && !prev) starts++;
            prev = BUSY;
            if (starts == 4) RUN = 1'b0;
            n++;
        end
        FULL_N = 1'b1;
        chk("t4_done", 32'(starts == 4 && exp_q.size() == 0 && !BUSY), 32'd1);
        chk("t4_rdreq_pulses", 32'(rd_cnt - base_rd), 32'd1012);
        chk("t4_frame_cnt", 32'(FRAME_CNT), 32'd3);
        cyc;
        force dut.seq_q = 16'hFFFF;
        cyc;
        cyc;
        release dut.seq_q;
        cyc;
        push_frame(16'hFFFF);
        push_frame(16'h0000);
        RUN = 1'b1;
        wait_busy;
        n = 0;
        while (BUSY && n < 600) begin cyc; n++; end
        chk("t5_frame_cnt_ffff", 32'(FRAME_CNT), 32'h0000FFFF);
        wait_busy;
        RUN = 1'b0;
        wait_done(600);
        chk("t5_frame_cnt_wrap", 32'(FRAME_CNT), 32'd0);
        push_frame(16'h0001);
        base_wr = wr_cnt;
        RUN = 1'b1;
        wait_wr(base_wr + 103);
        RUN = 1'b0;
        wait_done(600);
        repeat (300) cyc;
        chk("t6_words", 32'(wr_cnt - base_wr), 32'd256);
        chk("t6_busy", 32'(BUSY), 32'd0);
        chk("t6_frame_cnt", 32'(FRAME_CNT), 32'd1);
        push_frame(16'h0002);
        base_wr = wr_cnt;
        RUN = 1'b1;
        wait_wr(base_wr + 53);
        RST_N = 1'b0;
        RUN = 1'b0;
        #1;
        chk("t7_rst_slwr_n", 32'(SLWR_N), 32'd1);
        chk("t7_rst_rdreq", 32'(FIFO_RDREQ), 32'd0);
        chk("t7_rst_busy", 32'(BUSY), 32'd0);
        chk("t7_rst_fd", 32'(FD), 32'd0);
        exp_q.delete();
        cyc;
        cyc;
        RST_N = 1'b1;
        cyc;
        exp_ramp = ramp;
        one_frame(16'h0000);
        chk("t7_frame_cnt", 32'(FRAME_CNT), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
